md5_padder: RTL and testbench

//  Upstream feeder for the md5sum core. Accepts a byte stream and packs it into 32-bit little-endian words.

---
 rtl/md5_padder.sv | 238 +++++++++++++++++++++++
 tb/tb_md5_padder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_padder.sv
// md5_padder: byte-stream front end for the md5sum core.
// Packs bytes into little-endian 32-bit words and appends MD5 padding:
// 0x80, then zeros, then the 64-bit message bit length.
// Feeds the core one 16-word block at a time and waits for core_done between blocks.
// Optional feature macro: MD5_PADDER_BLKCNT_EN adds a saturating blk_cnt[15:0] output.
module md5_padder #(
    parameter int unsigned LEN_W = 61
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    output logic [31:0] out_msg,
    output logic        out_we,
    input  logic        core_rdy,
    input  logic        core_done,
    output logic        msg_done
`ifdef MD5_PADDER_BLKCNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLEN_W  = 64;
    localparam logic [3:0]  LAST_IDX = 4'd15;
    localparam logic [3:0]  LEN_IDX  = 4'd14;
    localparam logic [7:0]  PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_PAD,
        S_LENLO,
        S_LENHI,
        S_WAITD
    } state_t;

    state_t              state_q;
    logic [LEN_W-1:0]    byte_cnt_q;
    logic [BLEN_W-1:0]   bit_len_q;
    logic [1:0]          lane_q;
    logic [3:0]          word_idx_q;
    logic                pad_pending_q;   // 0x80 still owed at lane 0 of the next word
    logic                padding_q;       // message ended, padding/length still in progress
    logic                final_q;         // current block carries the length words
    logic                in_ready_q;
    logic                out_we_q;
    logic [WORD_W-1:0]   out_msg_q;
    logic                msg_done_q;

    logic                xfer_c;
    logic [LEN_W-1:0]    cnt_inc_c;
    logic [3:0]          word_idx_inc_c;
    logic [WORD_W-1:0]   asm_base_c;
    logic [WORD_W-1:0]   asm_byte_c;
    logic [WORD_W-1:0]   asm_term_c;
    logic [WORD_W-1:0]   asm_empty_c;
    logic [WORD_W-1:0]   pad_word_c;
    state_t              pad_state_c;

    assign in_ready = in_ready_q;
    assign out_we   = out_we_q;
    assign out_msg  = out_msg_q;
    assign msg_done = msg_done_q;

    assign xfer_c         = out_we_q & core_rdy;
    assign cnt_inc_c      = byte_cnt_q + LEN_W'(1);
    assign word_idx_inc_c = word_idx_q + 4'd1;

    // Word assembly: new byte in the current lane, optionally followed by the 0x80 terminator
    always_comb begin
        asm_base_c  = (lane_q == 2'd0) ? '0 : out_msg_q;
        asm_byte_c  = asm_base_c;
        asm_byte_c[{lane_q, 3'b000} +: 8] = in_data;
        asm_term_c  = asm_byte_c;
        asm_term_c[{lane_q + 2'd1, 3'b000} +: 8] = PAD_BYTE;
        asm_empty_c = asm_base_c;
        asm_empty_c[{lane_q, 3'b000} +: 8] = PAD_BYTE;
    end

    // Next padding word after a transfer: owed 0x80 first, low length word at index 14, else zero
    always_comb begin
        pad_word_c  = '0;
        pad_state_c = S_PAD;
        if (pad_pending_q) begin
            pad_word_c = WORD_W'(PAD_BYTE);
        end else if (word_idx_inc_c == LEN_IDX) begin
            pad_word_c  = bit_len_q[WORD_W-1:0];
            pad_state_c = S_LENLO;
        end
    end

    // Control FSM with registered handshake outputs and word datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            bit_len_q     <= '0;
            lane_q        <= '0;
            word_idx_q    <= '0;
            pad_pending_q <= 1'b0;
            padding_q     <= 1'b0;
            final_q       <= 1'b0;
            in_ready_q    <= 1'b0;
            out_we_q      <= 1'b0;
            out_msg_q     <= '0;
            msg_done_q    <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_LOAD;
                    in_ready_q <= 1'b1;
                end

                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        if (in_last) begin
                            state_q    <= S_SEND;
                            in_ready_q <= 1'b0;
                            out_we_q   <= 1'b1;
                            padding_q  <= 1'b1;
                            lane_q     <= '0;
                            if (in_empty) begin
                                bit_len_q <= BLEN_W'({byte_cnt_q, 3'b000});
                                out_msg_q <= asm_empty_c;
                            end else begin
                                byte_cnt_q <= cnt_inc_c;
                                bit_len_q  <= BLEN_W'({cnt_inc_c, 3'b000});
                                if (lane_q == 2'd3) begin
                                    out_msg_q     <= asm_byte_c;
                                    pad_pending_q <= 1'b1;
                                end else begin
                                    out_msg_q <= asm_term_c;
                                end
                            end
                        end else if (!in_empty) begin
                            byte_cnt_q <= cnt_inc_c;
                            out_msg_q  <= asm_byte_c;
                            lane_q     <= lane_q + 2'd1;
                            if (lane_q == 2'd3) begin
                                state_q    <= S_SEND;
                                in_ready_q <= 1'b0;
                                out_we_q   <= 1'b1;
                            end
                        end
                    end
                end

                S_SEND, S_PAD: begin
                    if (xfer_c) begin
                        word_idx_q <= word_idx_inc_c;
                        if (word_idx_q == LAST_IDX) begin
                            state_q  <= S_WAITD;
                            out_we_q <= 1'b0;
                        end else if (padding_q) begin
                            state_q       <= pad_state_c;
                            out_msg_q     <= pad_word_c;
                            pad_pending_q <= 1'b0;
                        end else begin
                            state_q    <= S_LOAD;
                            out_we_q   <= 1'b0;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                S_LENLO: begin
                    if (xfer_c) begin
                        word_idx_q <= word_idx_inc_c;
                        out_msg_q  <= bit_len_q[BLEN_W-1:WORD_W];
                        state_q    <= S_LENHI;
                    end
                end

                S_LENHI: begin
                    if (xfer_c) begin
                        word_idx_q <= word_idx_inc_c;
                        out_we_q   <= 1'b0;
                        final_q    <= 1'b1;
                        state_q    <= S_WAITD;
                    end
                end

                S_WAITD: begin
                    if (core_done) begin
                        if (final_q) begin
                            msg_done_q    <= 1'b1;
                            byte_cnt_q    <= '0;
                            lane_q        <= '0;
                            word_idx_q    <= '0;
                            pad_pending_q <= 1'b0;
                            padding_q     <= 1'b0;
                            final_q       <= 1'b0;
                            state_q       <= S_LOAD;
                            in_ready_q    <= 1'b1;
                        end else if (padding_q) begin
                            state_q       <= S_PAD;
                            out_we_q      <= 1'b1;
                            out_msg_q     <= pad_pending_q ? WORD_W'(PAD_BYTE) : '0;
                            pad_pending_q <= 1'b0;
                        end else begin
                            state_q    <= S_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    out_we_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MD5_PADDER_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    assign blk_cnt = blk_cnt_q;

    // Saturating count of blocks handed to the core, cleared after each message
    always_ff @(posedge clk) begin
        if (rst || msg_done_q) begin
            blk_cnt_q <= '0;
        end else if (xfer_c && (word_idx_q == LAST_IDX) && (blk_cnt_q != 16'hFFFF)) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md5_padder.sv
// Bench for md5_padder: table of padded messages plus hand sequences for
// spurious done, backpressure and mid-message reset, against a small core model.
module tb_md5_padder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_empty;
    logic [31:0] out_msg;
    logic        out_we;
    logic        core_rdy;
    logic        core_done;
    logic        msg_done;
`ifdef MD5_PADDER_BLKCNT_EN
    logic [15:0] blk_cnt;
    int          blk_at_done;
`endif

    md5_padder dut (
`ifdef MD5_PADDER_BLKCNT_EN
        .blk_cnt   (blk_cnt),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .out_msg   (out_msg),
        .out_we    (out_we),
        .core_rdy  (core_rdy),
        .core_done (core_done),
        .msg_done  (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        bit          sep;
        int          words;
        int          i1;
        logic [31:0] v1;
        int          i2;
        logic [31:0] v2;
    } vec_t;

    int          checks;
    int          failures;
    logic [31:0] cap[$];
    logic [7:0]  msg_q[$];
    int          wcnt, dcount, stall_left, ndone;
    int          stall_req, stall_ack, spur_req, spur_ack;
    int          proto_err, stab_err, stall_we_cnt;
    bit          hold_v;
    logic [31:0] hold_msg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] capw(input int i);
        if (i < cap.size()) return cap[i];
        return 32'hDEAD0000;
    endfunction

    // Core stand-in: takes words, pulses done after 16, optional stall and spurious done
    task automatic core_proc();
        forever begin
            @(negedge clk);
            if (rst) begin
                wcnt = 0; dcount = 0; stall_left = 0; hold_v = 0;
                core_rdy = 1'b1; core_done = 1'b0;
                stall_ack = stall_req; spur_ack = spur_req;
            end else begin
                core_done = 1'b0;
                if (dcount != 0) begin
                    dcount--;
                    if (dcount == 0) begin
                        core_done = 1'b1;
                        wcnt = 0;
                    end
                end
                if (spur_req != spur_ack) begin
                    spur_ack = spur_req;
                    core_done = 1'b1;
                end
                if (stall_left != 0) stall_left--;
                else if (stall_req != stall_ack && wcnt == 8 && out_we) begin
                    stall_ack = stall_req;
                    stall_left = 5;
                end
                core_rdy = (stall_left == 0);
                if (hold_v && (!out_we || out_msg != hold_msg)) stab_err++;
                if (out_we && !core_rdy) stall_we_cnt++;
                hold_v = out_we && !core_rdy;
                hold_msg = out_msg;
                if (out_we && core_rdy) begin
                    if (wcnt >= 16) proto_err++;
                    else begin
                        cap.push_back(out_msg);
                        wcnt++;
                        if (wcnt == 16) dcount = 3;
                    end
                end
                if (msg_done) begin
                    ndone++;
`ifdef MD5_PADDER_BLKCNT_EN
                    blk_at_done = int'(blk_cnt);
`endif
                end
            end
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int cyc;
        in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
        cyc = 0;
        while (!in_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) chk("beat accept timeout", 64'(cyc), 64'd0);
        @(negedge clk);
    endtask

    // Send msg_q, wait for msg_done, compare captured words to the padding model
    task automatic run_msg(input bit sep, input string tag);
        int n, d0, cyc, mism;
        logic [7:0]  bq[$];
        logic [31:0] ew[$];
        logic [63:0] blen;
        n = msg_q.size();
        cap.delete();
        d0 = ndone;
        for (int i = 0; i < n; i++) send_beat(msg_q[i], (i == n - 1) && !sep, 1'b0);
        if (n == 0 || sep) send_beat(8'h00, 1'b1, 1'b1);
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
        cyc = 0;
        while (ndone == d0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        chk({tag, " msg_done pulses"}, 64'(ndone - d0), 64'd1);
        bq = msg_q;
        bq.push_back(8'h80);
        while ((bq.size() % 64) != 56) bq.push_back(8'h00);
        blen = 64'(n) * 64'd8;
        for (int k = 0; k < 8; k++) bq.push_back(blen[8*k +: 8]);
        for (int k = 0; k < bq.size() / 4; k++)
            ew.push_back({bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]});
        chk({tag, " word count"}, 64'(cap.size()), 64'(ew.size()));
        mism = 0;
        for (int k = 0; k < ew.size(); k++) if (capw(k) !== ew[k]) mism++;
        chk({tag, " stream mismatches"}, 64'(mism), 64'd0);
`ifdef MD5_PADDER_BLKCNT_EN
        chk({tag, " blk_cnt at done"}, 64'(blk_at_done), 64'(ew.size() / 16));
        chk({tag, " blk_cnt cleared"}, 64'(blk_cnt), 64'd0);
`endif
    endtask

    task automatic abc_checks(input string tag);
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        run_msg(1'b0, tag);
        chk({tag, " w0"}, 64'(capw(0)), 64'h80636261);
        chk({tag, " w13"}, 64'(capw(13)), 64'h0);
        chk({tag, " w14"}, 64'(capw(14)), 64'h18);
        chk({tag, " w15"}, 64'(capw(15)), 64'h0);
    endtask

    vec_t tbl[7];

    initial begin
        int d0, cyc;
        checks = 0; failures = 0;
        ndone = 0; proto_err = 0; stab_err = 0; stall_we_cnt = 0;
        stall_req = 0; stall_ack = 0; spur_req = 0; spur_ack = 0;
        wcnt = 0; dcount = 0; stall_left = 0; hold_v = 0; hold_msg = '0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_empty = 1'b0;
        core_rdy = 1'b1; core_done = 1'b0;
`ifdef MD5_PADDER_BLKCNT_EN
        blk_at_done = 0;
`endif
        tbl[0] = '{0,   1'b0, 16, 0,  32'h00000080, 14, 32'h00000000};
        tbl[1] = '{55,  1'b0, 16, 13, 32'h80616161, 14, 32'h000001B8};
        tbl[2] = '{56,  1'b0, 32, 14, 32'h00000080, 30, 32'h000001C0};
        tbl[3] = '{64,  1'b0, 32, 16, 32'h00000080, 30, 32'h00000200};
        tbl[4] = '{3,   1'b1, 16, 0,  32'h80616161, 14, 32'h00000018};
        tbl[5] = '{4,   1'b0, 16, 1,  32'h00000080, 14, 32'h00000020};
        tbl[6] = '{120, 1'b0, 48, 30, 32'h00000080, 46, 32'h000003C0};

        fork
            core_proc();
        join_none

        repeat (3) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_we", 64'(out_we), 64'd0);
        chk("reset out_msg", 64'(out_msg), 64'd0);
        chk("reset msg_done", 64'(msg_done), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            msg_q.delete();
            for (int j = 0; j < tbl[v].n; j++) msg_q.push_back(8'h61);
            run_msg(tbl[v].sep, tag);
            chk({tag, " words"}, 64'(cap.size()), 64'(tbl[v].words));
            chk($sformatf("%s w%0d", tag, tbl[v].i1), 64'(capw(tbl[v].i1)), 64'(tbl[v].v1));
            chk($sformatf("%s w%0d", tag, tbl[v].i2), 64'(capw(tbl[v].i2)), 64'(tbl[v].v2));
        end

        // core_done while loading is ignored
        d0 = ndone;
        spur_req++;
        repeat (6) @(negedge clk);
        chk("spurious done msg_done", 64'(ndone - d0), 64'd0);
        abc_checks("abc");

        // backpressure: core_rdy low for 5 cycles with word 8 on the bus
        msg_q.delete();
        for (int j = 0; j < 55; j++) msg_q.push_back(8'(j));
        stall_we_cnt = 0;
        stall_req++;
        run_msg(1'b0, "bp");
        chk("bp held cycles", 64'(stall_we_cnt), 64'd5);
        chk("bp w13", 64'(capw(13)), 64'h80363534);

        // reset while word 7 of a block is being assembled
        cap.delete();
        for (int j = 0; j < 30; j++) send_beat(8'(j), 1'b0, 1'b0);
        in_valid = 1'b0;
        cyc = 0;
        while (cap.size() < 7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid words before reset", 64'(cap.size()), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid in_ready", 64'(in_ready), 64'd0);
        chk("rstmid out_we", 64'(out_we), 64'd0);
        chk("rstmid out_msg", 64'(out_msg), 64'd0);
        chk("rstmid msg_done", 64'(msg_done), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        abc_checks("abc after reset");

        chk("word sent before core_done", 64'(proto_err), 64'd0);
        chk("out_msg/out_we unstable under stall", 64'(stab_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
